// File: rtl/perceptron_layer_seq.sv
// Time-multiplexed binary-input perceptron layer: walks N_IN inputs serially into
// N_OUT parallel accumulators, then registers one firing bit per neuron.
module perceptron_layer_seq #(
  parameter  int unsigned N_IN   = 8,
  parameter  int unsigned N_OUT  = 8,
  parameter  int unsigned W_BITS = 4,
  localparam int unsigned ACC_W  = W_BITS + $clog2(N_IN + 1),
  localparam int unsigned NEUR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int unsigned IDX_W  = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_IN-1:0]   x,
  input  logic              wr_en,
  input  logic              wr_thr,
  input  logic [NEUR_W-1:0] wr_neur,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ACC_W-1:0]  wr_data,
  output logic [N_OUT-1:0]  y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [W_BITS-1:0]  r_w   [N_OUT][N_IN];
  logic [ACC_W-1:0]   r_thr [N_OUT];
  logic [ACC_W-1:0]   r_acc [N_OUT];
  logic [N_IN-1:0]    r_xq;
  logic [IDX_W-1:0]   r_idx;
  logic [N_OUT-1:0]   r_y;
  logic               r_busy;
  logic               r_done;

  logic               w_wr_ok;
  logic               w_x_bit;

  // Writes only land while idle and in range; anything else is silently dropped.
  assign w_wr_ok = wr_en && (r_state == S_IDLE) && (32'(wr_neur) < N_OUT) &&
                   (wr_thr || (32'(wr_idx) < N_IN));
  assign w_x_bit = r_xq[r_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ACC;
      S_ACC:   if (r_idx == IDX_W'(N_IN - 1)) w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register file, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(N_OUT); j++) begin
        for (int i = 0; i < int'(N_IN); i++) r_w[j][i] <= '0;
        r_thr[j] <= '0;
        r_acc[j] <= '0;
      end
      r_xq   <= '0;
      r_idx  <= '0;
      r_y    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        if (wr_thr) r_thr[wr_neur]      <= wr_data;
        else        r_w[wr_neur][wr_idx] <= wr_data[W_BITS-1:0];
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xq  <= x;
            r_idx <= '0;
            for (int j = 0; j < int'(N_OUT); j++) r_acc[j] <= '0;
          end
        end
        S_ACC: begin
          for (int j = 0; j < int'(N_OUT); j++)
            r_acc[j] <= r_acc[j] + (w_x_bit ? ACC_W'(r_w[j][r_idx]) : ACC_W'(0));
          r_idx <= r_idx + IDX_W'(1);
        end
        S_CMP: begin
          for (int j = 0; j < int'(N_OUT); j++) r_y[j] <= (r_acc[j] > r_thr[j]);
        end
        default: ;
      endcase

      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_CMP);
    end
  end

  assign y    = r_y;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Randomized self-checking bench for perceptron_layer_seq against an arithmetic
// model of the weight/threshold store and the firing rule.
module tb_perceptron_layer_seq;

  localparam int unsigned N_IN   = 8;
  localparam int unsigned N_OUT  = 8;
  localparam int unsigned W_BITS = 4;
  localparam int unsigned ACC_W  = W_BITS + $clog2(N_IN + 1);
  localparam int unsigned NEUR_W = $clog2(N_OUT);
  localparam int unsigned IDX_W  = $clog2(N_IN);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [N_IN-1:0]   x = '0;
  logic              wr_en = 1'b0;
  logic              wr_thr = 1'b0;
  logic [NEUR_W-1:0] wr_neur = '0;
  logic [IDX_W-1:0]  wr_idx = '0;
  logic [ACC_W-1:0]  wr_data = '0;
  logic [N_OUT-1:0]  y;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  int m_w   [N_OUT][N_IN];
  int m_thr [N_OUT];

  perceptron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .W_BITS(W_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x),
    .wr_en(wr_en), .wr_thr(wr_thr), .wr_neur(wr_neur), .wr_idx(wr_idx),
    .wr_data(wr_data), .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_OUT-1:0] model_y(input logic [N_IN-1:0] xv);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      int s;
      s = 0;
      for (int i = 0; i < int'(N_IN); i++) if (xv[i]) s += m_w[j][i];
      r[j] = (s > m_thr[j]);
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < int'(N_OUT); j++) begin
      m_thr[j] = 0;
      for (int i = 0; i < int'(N_IN); i++) m_w[j][i] = 0;
    end
  endtask

  task automatic do_wr(input bit t, input int n, input int i, input int d);
    wr_en = 1'b1; wr_thr = t; wr_neur = NEUR_W'(n); wr_idx = IDX_W'(i); wr_data = ACC_W'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (t) m_thr[n] = d;
    else   m_w[n][i] = d % (1 << W_BITS);
  endtask

  // Any write signals already driven are sampled with start; collide injects a
  // start plus a w[0][0]=0 write mid-evaluation, both of which must be dropped.
  task automatic run_eval(input string tag, input logic [N_IN-1:0] xv, input bit collide);
    logic [N_OUT-1:0] exp_y;
    exp_y = model_y(xv);
    x = xv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0; x = ~xv;
    check_eq({tag, ":busy0"}, 32'(busy), 32'd1);
    check_eq({tag, ":done0"}, 32'(done), 32'd0);
    for (int c = 1; c <= int'(N_IN) + 1; c++) begin
      if (collide && c == 3) begin
        start = 1'b1; wr_en = 1'b1; wr_thr = 1'b0; wr_neur = '0; wr_idx = '0; wr_data = '0;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      check_eq({tag, ":busy"}, 32'(busy), (c <= int'(N_IN)) ? 32'd1 : 32'd0);
      check_eq({tag, ":done"}, 32'(done), (c == int'(N_IN) + 1) ? 32'd1 : 32'd0);
    end
    check_eq({tag, ":y"}, 32'(y), 32'(exp_y));
    @(posedge clk); #1;
    check_eq({tag, ":hold_y"}, 32'(y), 32'(exp_y));
    check_eq({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, ":idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic fill_all(input int wv, input int tv);
    for (int j = 0; j < int'(N_OUT); j++) begin
      for (int i = 0; i < int'(N_IN); i++) do_wr(1'b0, j, i, wv);
      do_wr(1'b1, j, 0, tv);
    end
  endtask

  initial begin
    int wts [N_IN];
    wts = '{2, 4, 2, 1, 5, 2, 2, 2};
    model_clear();

    // reset defaults
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst:y", 32'(y), 32'd0);
    check_eq("rst:busy", 32'(busy), 32'd0);
    check_eq("rst:done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_eval("dflt", 8'hFF, 1'b0);

    // single neuron
    for (int i = 0; i < int'(N_IN); i++) do_wr(1'b0, 0, i, wts[i]);
    do_wr(1'b1, 0, 0, 10);
    run_eval("n0_sum6", 8'b0000_0011, 1'b0);
    check_eq("n0_sum6:y0", 32'(y[0]), 32'd0);
    run_eval("n0_sum11", 8'b0001_0011, 1'b0);
    check_eq("n0_sum11:y0", 32'(y[0]), 32'd1);

    // threshold boundary
    fill_all(1, 8);
    run_eval("thr8", 8'hFF, 1'b0);
    check_eq("thr8:lit", 32'(y), 32'h00);
    for (int j = 0; j < int'(N_OUT); j++) do_wr(1'b1, j, 0, 7);
    run_eval("thr7", 8'hFF, 1'b0);
    check_eq("thr7:lit", 32'(y), 32'hFF);

    // width limit
    fill_all(15, 119);
    run_eval("w15_t119", 8'hFF, 1'b0);
    check_eq("w15_t119:lit", 32'(y), 32'hFF);
    for (int j = 0; j < int'(N_OUT); j++) do_wr(1'b1, j, 0, 120);
    run_eval("w15_t120", 8'hFF, 1'b0);
    check_eq("w15_t120:lit", 32'(y), 32'h00);

    // collision: busy-time start and write are dropped
    do_wr(1'b1, 0, 0, 119);
    run_eval("coll", 8'hFF, 1'b1);
    run_eval("coll_reread", 8'hFF, 1'b0);
    check_eq("coll_reread:y0", 32'(y[0]), 32'd1);

    // reset mid-evaluation (y is nonzero going in)
    x = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid:busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid:busy", 32'(busy), 32'd0);
    check_eq("mid:done", 32'(done), 32'd0);
    check_eq("mid:y", 32'(y), 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_eq("mid:no_done", 32'(done), 32'd0);
    end
    run_eval("post_rst", 8'hFF, 1'b0);

    // randomized weights, thresholds and inputs
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = int'($urandom_range(2, 12));
      for (int k = 0; k < nw; k++)
        do_wr(1'b0, int'($urandom_range(0, N_OUT - 1)), int'($urandom_range(0, N_IN - 1)),
              int'($urandom_range(0, 255)));
      for (int j = 0; j < int'(N_OUT); j++)
        if ($urandom_range(0, 1) == 1) do_wr(1'b1, j, 0, int'($urandom_range(0, 60)));
      if ($urandom_range(0, 1) == 1) begin
        int n, d;
        n = int'($urandom_range(0, N_OUT - 1));
        d = int'($urandom_range(0, 60));
        wr_en = 1'b1; wr_thr = 1'b1; wr_neur = NEUR_W'(n); wr_idx = '0; wr_data = ACC_W'(d);
        m_thr[n] = d;
      end
      run_eval("rand", N_IN'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perceptron_layer_seq.md
# perceptron_layer_seq

Parametrised, time-multiplexed binary-input perceptron layer. It is the runtime-loadable successor to our fixed-weight perceptron network. Weights and thresholds live in on-chip registers written over a simple write port. An evaluation walks the N_IN inputs serially, one per clock, into N_OUT parallel accumulators, then registers one firing bit per neuron. It sits between the input switch bank and the output display/logic inside the top-level user wrapper.

## Interface
- N_IN, 8: number of binary inputs per neuron (≥2).
- N_OUT, 8: number of neurons / output bits (≥1).
- W_BITS, 4: unsigned weight width.
- ACC_W, W_BITS+$clog2(N_IN+1): accumulator and threshold width (derived; not overridden).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request evaluation of x; sampled only in IDLE.
- x  in  N_IN  binary input vector; bit i multiplies weight index i.
- wr_en  in  1  register write strobe.
- wr_thr  in  1  1 = write threshold of neuron wr_neur; 0 = write weight.
- wr_neur  in  $clog2(N_OUT)  neuron index.
- wr_idx  in  $clog2(N_IN)  weight index (ignored when wr_thr=1).
- wr_data  in  ACC_W  write data; weight writes use the low W_BITS bits.
- y  out  N_OUT  registered firing vector; bit j = neuron j.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse when y updates.

## Operation
- Storage: N_OUT×N_IN weights w[j][i] (W_BITS, unsigned) and N_OUT thresholds thr[j] (ACC_W, unsigned). All reset to 0.
- Neuron rule: y[j] = (Σ_i x[i]·w[j][i]) > thr[j], a strict compare. Unsigned arithmetic.
- ACC_W guarantees no overflow: the maximum sum N_IN·(2^W_BITS−1) fits.
- Writes:
  - Accepted in IDLE only.
  - wr_en while busy is discarded with no side effect.
  - Out-of-range wr_neur or wr_idx (non-power-of-2 sizes) is discarded.
  - A write takes effect at the edge on which it is sampled, so it is visible to a start sampled at the next edge.
- FSM:
  - IDLE: when start=1, latch x into x_q, clear all accumulators, set idx=0, go to ACC.
  - ACC: every cycle, acc[j] += x_q[idx] ? w[j][idx] : 0 for all j, then idx++. After the idx=N_IN−1 cycle, go to CMP.
  - CMP: y[j] ← acc[j] > thr[j] for all j; pulse done; go to IDLE.
- start while busy is ignored; it is not queued. x changes after latch have no effect.
- y holds its value between evaluations and changes only in CMP or reset.
- Reset sampled low in any state forces: state=IDLE, y=0, busy=0, done=0, accumulators=0, idx=0, all weights and thresholds=0. An in-flight evaluation is abandoned and no done pulse is issued.

## Timing
- Reset values: y=0, busy=0, done=0.
- Let start be sampled at edge k in IDLE:
  - busy=1 from after edge k through the cycle ending at edge k+N_IN+1.
  - ACC occupies edges k+1 … k+N_IN.
  - CMP occurs at edge k+N_IN+1: y is valid and done=1 for exactly one cycle after it, and busy=0 in that same cycle.
- Latency from start to y/done is N_IN+1 cycles. Throughput is one evaluation per N_IN+2 cycles, because a start asserted during the done cycle is accepted at the next edge.
- busy and done are never high together.
- A write sampled in the same cycle as start is performed, and the evaluation uses the new value.

## Test plan
- Reset defaults: release reset, pulse start with x=8'hFF → busy high 9 cycles, done pulses 9 cycles after start, y=8'h00.
- Single neuron: load neuron 0 weights [2,4,2,1,5,2,2,2] (idx 0..7), thr[0]=10, x=8'b0000_0011 (sum 6) → y[0]=0. Then x=8'b0001_0011 (sum 11) → y[0]=1.
- Threshold boundary: all weights 1, thr=8, x=8'hFF → y=8'h00. Set thr=7 → y=8'hFF.
- Width limit: all weights 15, x=8'hFF (sum 120, ACC_W=8), thr=119 → y=8'hFF. With thr=120 → y=8'h00.
- Collisions: assert start and a weight write to w[0][0] in cycle 3 of an evaluation → result unchanged from the pre-write weights, no restart, and a re-read by a fresh evaluation shows the old weight.
- Reset mid-evaluation: drop rst_n at ACC cycle 4 → next edge gives busy=0, done=0, y=0. Weights read back as 0 through an x=8'hFF, thr=0 evaluation (y=0).
